knn_ctrl: RTL and testbench
===========================

Name: knn_ctrl

Overview:
- Sequencer for the KNN datapath: for one test point, walks n_train training points held in an external memory.
- For each point it fetches via a req/ack handshake, then drives the dist_core phase controls (en_reg, rst_acc, en_acc, sel_xy).
- It pulses valid so the neighbour list can insert the candidate.
- Sits between the CPU-visible register file (run/n_train/busy/done) and knn_core; test point A is supplied to knn_core elsewhere.

Parameters:
- DATA_W, 32, packed training point width ({x[31:16], y[15:0]}).
- LABEL, 8, label width.
- ADDR_W, 10, training memory address / point count width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- run  input  1  one-cycle request to start classification
- abort  input  1  cancel current run
- n_train  input  ADDR_W  number of training points, sampled on accepted run
- busy  output  1  high from accepted run until DONE/abort
- done  output  1  one-cycle pulse at end of a complete run
- mem_req  output  1  read request, held until mem_ack
- mem_addr  output  ADDR_W  training point index, stable while mem_req
- mem_ack  input  1  read data valid this cycle
- mem_data  input  DATA_W  training point
- mem_label  input  LABEL  training label
- B  output  DATA_W  registered training point to knn_core
- label  output  LABEL  registered label to knn_core
- start  output  1  list clear pulse
- en_reg  output  1  dist_core operand register enable
- rst_acc  output  1  dist_core accumulator clear
- en_acc  output  1  dist_core accumulate enable
- sel_xy  output  1  0 = x coordinate, 1 = y coordinate
- valid  output  1  candidate insert strobe to list

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. All outputs 0: busy, done, mem_req, mem_addr, B, label, start, en_reg, rst_acc, en_acc, sel_xy, valid. Index counter 0.
- All control outputs are decoded from registered state (Moore); no combinational path from mem_ack to any output.
- States and transitions:
  - IDLE: on run=1, latch n_train into cnt_max, idx<=0, go CLR. Otherwise stay.
  - CLR: start=1, busy=1, one cycle. Next state: DONE if cnt_max==0, else REQ.
  - REQ: mem_req=1, mem_addr=idx. On mem_ack=1, capture B<=mem_data and label<=mem_label, go LOAD. Otherwise stay; there is no timeout.
  - LOAD: en_reg=1, rst_acc=1, one cycle.
  - ACC_X: en_acc=1, sel_xy=0, one cycle.
  - ACC_Y: en_acc=1, sel_xy=1, one cycle.
  - PUSH: valid=1, one cycle; DIST_OUT is final this cycle. If idx==cnt_max-1 go DONE, else idx<=idx+1 and go REQ.
  - DONE: done=1, busy=0, one cycle, then IDLE.
- busy is 1 in CLR..PUSH.
- Latency with zero-wait memory (ack in first REQ cycle): run accepted at cycle 0, CLR at 1, points take 5 cycles each, done at cycle 2+5N. Each wait cycle on mem_ack adds 1.
- run while not IDLE: ignored. n_train changes after acceptance: ignored.
- n_train = 2^ADDR_W-1: legal, last address is cnt_max-1. idx never wraps.
- abort=1 in any non-IDLE state: next state IDLE. All strobes and mem_req drop the following cycle, done is not pulsed, and list contents are undefined. abort has priority over mem_ack and run. abort in IDLE has no effect.
- rst mid-run: identical to abort, and additionally clears B/label/mem_addr.
- mem_ack outside REQ: ignored.

Decomposition:
- Shared header knn_ctrl.vh (Verilog include, alongside iob_lib.vh) holds:
  - state encoding localparams: IDLE, CLR, REQ, LOAD, ACC_X, ACC_Y, PUSH, DONE;
  - SEL_X=0 / SEL_Y=1;
  - the point layout macros X_MSB/X_LSB/Y_MSB/Y_LSB shared with knn_core.
- One sub-module, knn_idx_cnt: ADDR_W counter with sync clear, increment enable, and a last flag (idx==max-1). It is reusable for a later multi-test-point loop.

Test Plan:
- n_train=3, zero-wait memory, points (1,1),(5,2),(0,7) with labels 4,9,2 -> done at cycle 17 after run. Exactly 3 valid pulses with label 4,9,2. sel_xy 0 then 1 inside each point. One start pulse at cycle 1.
- n_train=2, mem_ack delayed 3 cycles on index 1 -> mem_req and mem_addr=1 held 4 cycles. B unchanged until ack. done at cycle 15.
- n_train=0 -> CLR then DONE. start=1 at cycle 1, done=1 at cycle 2, mem_req never asserted.
- abort asserted during ACC_X of point 1 (n_train=4) -> IDLE next cycle. No further valid, done never pulses. A following run with n_train=1 completes normally.
- run pulsed again while busy, plus mem_ack pulsed while IDLE -> no state change, no capture of mem_data.
- rst asserted during REQ -> all outputs 0 next cycle, mem_addr=0, state IDLE.

Source files
------------

// File: rtl/knn_ctrl_pkg.sv
// Shared definitions for the KNN sequencer: FSM state encoding, coordinate
// select values and the packed training-point layout used with knn_core.
package knn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    REQ,
    LOAD,
    ACC_X,
    ACC_Y,
    PUSH,
    DONE
  } state_e;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  // Packed point is {x, y}; knn_core slices operands with these bounds.
  localparam int X_MSB = 31;
  localparam int X_LSB = 16;
  localparam int Y_MSB = 15;
  localparam int Y_LSB = 0;

endpackage

// File: rtl/knn_idx_cnt.sv
// Point index counter with synchronous clear, increment enable and a flag
// raised when the index sits on the last point (idx == max-1).
module knn_idx_cnt #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] max_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == max_i - ADDR_W'(1));

endmodule

// File: rtl/knn_ctrl.sv
// KNN sequencer: walks n_train training points for one test point, fetching
// each over req/ack and stepping dist_core through load, x, y and push phases.
module knn_ctrl
  import knn_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LABEL  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              abort,
  input  logic [ADDR_W-1:0] n_train,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [LABEL-1:0]  mem_label,
  output logic [DATA_W-1:0] B,
  output logic [LABEL-1:0]  label,
  output logic              start,
  output logic              en_reg,
  output logic              rst_acc,
  output logic              en_acc,
  output logic              sel_xy,
  output logic              valid
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_max_q, cnt_max_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [LABEL-1:0]  label_q, label_d;
  logic [ADDR_W-1:0] idx;
  logic              last;
  logic              accept, capture, inc;

  assign accept  = (state_q == IDLE) && run;
  assign capture = (state_q == REQ) && mem_ack && !abort;
  assign inc     = (state_q == PUSH) && !last && !abort;

  knn_idx_cnt #(.ADDR_W(ADDR_W)) u_idx_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .inc_i  (inc),
    .max_i  (cnt_max_q),
    .idx_o  (idx),
    .last_o (last)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default every comb output first; a missed branch would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = CLR;
      CLR:     state_d = (cnt_max_q == '0) ? DONE : REQ;
      REQ:     if (mem_ack) state_d = LOAD;
      LOAD:    state_d = ACC_X;
      ACC_X:   state_d = ACC_Y;
      ACC_Y:   state_d = PUSH;
      PUSH:    state_d = last ? DONE : REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort outranks mem_ack and run, but only once a run is in flight
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    cnt_max_d = accept  ? n_train   : cnt_max_q;
    b_d       = capture ? mem_data  : b_q;
    label_d   = capture ? mem_label : label_q;
  end

  // NOTE: datapath registers are reset here because they are visible outputs
  // that must read as zero after rst; pure storage arrays would not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_max_q <= '0;
      b_q       <= '0;
      label_q   <= '0;
    end else begin
      cnt_max_q <= cnt_max_d;
      b_q       <= b_d;
      label_q   <= label_d;
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    mem_req = 1'b0;
    start   = 1'b0;
    en_reg  = 1'b0;
    rst_acc = 1'b0;
    en_acc  = 1'b0;
    sel_xy  = SEL_X;
    valid   = 1'b0;
    case (state_q)
      CLR: begin
        busy  = 1'b1;
        start = 1'b1;
      end
      REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
      end
      LOAD: begin
        busy    = 1'b1;
        en_reg  = 1'b1;
        rst_acc = 1'b1;
      end
      ACC_X: begin
        busy   = 1'b1;
        en_acc = 1'b1;
        sel_xy = SEL_X;
      end
      ACC_Y: begin
        busy   = 1'b1;
        en_acc = 1'b1;
        sel_xy = SEL_Y;
      end
      PUSH: begin
        busy  = 1'b1;
        valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign mem_addr = idx;
  assign B        = b_q;
  assign label    = label_q;

endmodule

// File: tb/tb_knn_ctrl.sv
// Scoreboard bench for knn_ctrl: directed runs push expected start/valid/done
// events; a monitor pops and compares them as the DUT strobes its outputs.
module tb_knn_ctrl;

  localparam int DATA_W = 32;
  localparam int LBL_W  = 8;
  localparam int ADDR_W = 10;

  localparam logic [2:0] K_START = 3'b100;
  localparam logic [2:0] K_VALID = 3'b010;
  localparam logic [2:0] K_DONE  = 3'b001;

  logic              clk = 1'b0;
  logic              rst, run, abort;
  logic [ADDR_W-1:0] n_train;
  logic              busy, done, mem_req, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data, B;
  logic [LBL_W-1:0]  mem_label, label;
  logic              start, en_reg, rst_acc, en_acc, sel_xy, valid;

  knn_ctrl #(.DATA_W(DATA_W), .LABEL(LBL_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort), .n_train(n_train),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .mem_label(mem_label),
    .B(B), .label(label), .start(start), .en_reg(en_reg), .rst_acc(rst_acc),
    .en_acc(en_acc), .sel_xy(sel_xy), .valid(valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  kind;
    int          cyc;
    logic [31:0] b;
    logic [7:0]  l;
  } ev_t;

  ev_t         sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_d[8];
  logic [7:0]  mem_l[8];
  int          delay[8];
  logic        stray_ack;
  logic [31:0] stray_data;
  logic [7:0]  stray_label;
  logic [31:0] b_prev;
  logic [7:0]  l_prev;
  int          req_cycles, req_addr1;
  int          c0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic exp_ev(input logic [2:0] kind, input int c, input logic [31:0] b, input logic [7:0] l);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.b    = b;
    e.l    = l;
    sb.push_back(e);
  endtask

  // Memory responder: acks after delay[addr] wait cycles and checks B/addr hold.
  initial begin
    int wait_cnt = 0;
    logic [ADDR_W-1:0] held = '0;
    mem_ack = 1'b0; mem_data = '0; mem_label = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        if (mem_addr == 10'd1) req_addr1++;
        check("B_hold", B, b_prev);
        check("label_hold", label, l_prev);
        if (wait_cnt > 0) check("addr_stable", mem_addr, held);
        held = mem_addr;
        if (wait_cnt == delay[mem_addr[2:0]]) begin
          mem_ack   = 1'b1;
          mem_data  = mem_d[mem_addr[2:0]];
          mem_label = mem_l[mem_addr[2:0]];
          b_prev    = mem_d[mem_addr[2:0]];
          l_prev    = mem_l[mem_addr[2:0]];
          wait_cnt  = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack   = stray_ack;
        mem_data  = stray_data;
        mem_label = stray_label;
        wait_cnt  = 0;
      end
    end
  end

  // Monitor: pops one expected event per start/valid/done strobe.
  initial begin
    logic [1:0] h1 = '0, h2 = '0;
    logic [2:0] k;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        k = {start, valid, done};
        if (k != 3'b000) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %b at cycle %0d, expected no event", k, cyc);
          end else begin
            e = sb.pop_front();
            check("ev_kind", k, e.kind);
            check("ev_cycle", cyc, e.cyc);
            if (e.kind == K_VALID) begin
              check("valid_B", B, e.b);
              check("valid_label", label, e.l);
              check("acc_seq", {h2, h1}, 4'b1011);
            end
          end
        end
      end
      h2 = h1;
      h1 = {en_acc, sel_xy};
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, mem_req, start, en_reg, rst_acc, en_acc, sel_xy, valid}, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_B"}, B, 0);
    check({tag, "_label"}, label, 0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; abort = 1'b0; n_train = '0;
    stray_ack = 1'b0; stray_data = '0; stray_label = '0;
    b_prev = '0; l_prev = '0; req_cycles = 0; req_addr1 = 0;
    for (int i = 0; i < 8; i++) begin
      mem_d[i] = '0; mem_l[i] = '0; delay[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // n_train=3, zero wait; extra run pulses and n_train change mid-run ignored
    mem_d[0] = 32'h0001_0001; mem_l[0] = 8'd4;
    mem_d[1] = 32'h0005_0002; mem_l[1] = 8'd9;
    mem_d[2] = 32'h0000_0007; mem_l[2] = 8'd2;
    @(negedge clk);
    c0 = cyc; req_cycles = 0;
    exp_ev(K_START, c0 + 1, 0, 0);
    exp_ev(K_VALID, c0 + 6, 32'h0001_0001, 8'd4);
    exp_ev(K_VALID, c0 + 11, 32'h0005_0002, 8'd9);
    exp_ev(K_VALID, c0 + 16, 32'h0000_0007, 8'd2);
    exp_ev(K_DONE, c0 + 17, 0, 0);
    n_train = 10'd3; run = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      n_train = 10'd7;
      run = (j == 8) || (j == 12);
    end
    check("t1_drain", sb.size(), 0);
    check("t1_req_cycles", req_cycles, 3);

    // n_train=2, index 1 waits 3 cycles for ack
    mem_d[0] = 32'h0003_0004; mem_l[0] = 8'd1;
    mem_d[1] = 32'h0008_0008; mem_l[1] = 8'd6;
    delay[1] = 3;
    c0 = cyc; req_cycles = 0; req_addr1 = 0;
    exp_ev(K_START, c0 + 1, 0, 0);
    exp_ev(K_VALID, c0 + 6, 32'h0003_0004, 8'd1);
    exp_ev(K_VALID, c0 + 14, 32'h0008_0008, 8'd6);
    exp_ev(K_DONE, c0 + 15, 0, 0);
    n_train = 10'd2; run = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      run = 1'b0;
    end
    delay[1] = 0;
    check("t2_drain", sb.size(), 0);
    check("t2_addr1_hold", req_addr1, 4);
    check("t2_req_cycles", req_cycles, 5);

    // n_train=0: CLR straight to DONE, no memory traffic
    c0 = cyc; req_cycles = 0;
    exp_ev(K_START, c0 + 1, 0, 0);
    exp_ev(K_DONE, c0 + 2, 0, 0);
    n_train = 10'd0; run = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      run = 1'b0;
    end
    check("t3_drain", sb.size(), 0);
    check("t3_req_cycles", req_cycles, 0);

    // stray mem_ack while idle must not capture
    stray_data = 32'hDEAD_BEEF; stray_label = 8'hA5; stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_B", B, 32'h0008_0008);
    check("stray_label", label, 8'd6);
    stray_ack = 1'b0;
    @(negedge clk);

    // abort during ACC_X of point 1, n_train=4
    mem_d[0] = 32'h0002_0002; mem_l[0] = 8'd3;
    mem_d[1] = 32'h0004_0001; mem_l[1] = 8'd7;
    mem_d[2] = 32'h0006_0006; mem_l[2] = 8'd8;
    mem_d[3] = 32'h0001_0009; mem_l[3] = 8'd5;
    c0 = cyc; req_cycles = 0;
    exp_ev(K_START, c0 + 1, 0, 0);
    exp_ev(K_VALID, c0 + 6, 32'h0002_0002, 8'd3);
    n_train = 10'd4; run = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      run = 1'b0;
      if (j == 9) begin
        check("t4_in_accx", {en_acc, sel_xy, mem_addr}, {1'b1, 1'b0, 10'd1});
        abort = 1'b1;
      end
      if (j == 10) begin
        abort = 1'b0;
        check("t4_abort", {busy, mem_req, en_reg, rst_acc, en_acc, valid, done}, 0);
      end
    end
    check("t4_drain", sb.size(), 0);
    check("t4_req_cycles", req_cycles, 2);

    // run after abort with n_train=1 completes normally
    c0 = cyc;
    exp_ev(K_START, c0 + 1, 0, 0);
    exp_ev(K_VALID, c0 + 6, 32'h0002_0002, 8'd3);
    exp_ev(K_DONE, c0 + 7, 0, 0);
    n_train = 10'd1; run = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      run = 1'b0;
    end
    check("t4b_drain", sb.size(), 0);

    // rst while waiting in REQ on index 1
    mem_d[0] = 32'h0007_0003; mem_l[0] = 8'd11;
    delay[1] = 20;
    c0 = cyc;
    exp_ev(K_START, c0 + 1, 0, 0);
    exp_ev(K_VALID, c0 + 6, 32'h0007_0003, 8'd11);
    n_train = 10'd2; run = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      run = 1'b0;
      if (j == 9) begin
        check("t5_in_req", {mem_req, mem_addr}, {1'b1, 10'd1});
        rst = 1'b1;
      end
      if (j == 10) begin
        check_zero("t5_rst");
        rst = 1'b0;
        b_prev = '0;
        l_prev = '0;
      end
    end
    delay[1] = 0;
    check("t5_drain", sb.size(), 0);
    check("t5_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
